lowent_prefix_ctrl: RTL and testbench

//  Sequencer for the low-entropy codebook matcher of the hybrid entropy coder. Keeps one

---
 rtl/lowent_prefix_ctrl_pkg.sv | 30 +++
 rtl/lowent_prefix_ctrl_ap_bank.sv | 67 ++++++
 rtl/lowent_prefix_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_lowent_prefix_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lowent_prefix_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the low-entropy prefix sequencer.
package lowent_prefix_ctrl_pkg;

    localparam int NUM_CB              = 12;
    localparam int SYM_W               = 4;
    localparam int CODEBOOK_LENGTH_MAX = 64;
    localparam int ENCODE_DATALENGTH   = 21;
    localparam int AP_MAX_SYM          = CODEBOOK_LENGTH_MAX / SYM_W;

    localparam int CODE_W = 4;
    localparam int CNT_W  = 6;
    localparam int LEN_W  = 7;

    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NUM_CB - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(AP_MAX_SYM);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_EMIT   = 3'd2,
        ST_FSCAN  = 3'd3,
        ST_FEMIT  = 3'd4
    } state_t;

    // Raw prefix length in bits for a flush record.
    function automatic logic [LEN_W-1:0] cnt_to_bits(input logic [CNT_W-1:0] cnt);
        return LEN_W'({1'b0, cnt} * LEN_W'(SYM_W));
    endfunction

endpackage

// File: rtl/lowent_prefix_ctrl_ap_bank.sv
// Active-prefix register file: one {cnt, data} entry per codebook,
// one combinational read port by index, one write port with clear.
module lowent_prefix_ctrl_ap_bank
    import lowent_prefix_ctrl_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [CODE_W-1:0]              rd_idx_i,
    output logic [CNT_W-1:0]               rd_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] rd_data_o,
    input  logic                           wr_en_i,
    input  logic                           wr_clr_i,
    input  logic [CODE_W-1:0]              wr_idx_i,
    input  logic [CNT_W-1:0]               wr_cnt_i,
    input  logic [CODEBOOK_LENGTH_MAX-1:0] wr_data_i
);

    logic [CNT_W-1:0]               cnt_all  [NUM_CB];
    logic [CODEBOOK_LENGTH_MAX-1:0] data_all [NUM_CB];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CB; gi++) begin : g_entry
            logic                           wr_sel;
            logic [CNT_W-1:0]               cnt_q;
            logic [CNT_W-1:0]               cnt_d;
            logic [CODEBOOK_LENGTH_MAX-1:0] data_q;
            logic [CODEBOOK_LENGTH_MAX-1:0] data_d;

            assign wr_sel       = wr_en_i && (wr_idx_i == CODE_W'(gi));
            assign cnt_all[gi]  = cnt_q;
            assign data_all[gi] = data_q;

            // Next entry value: hold, overwrite, or clear to empty.
            always_comb begin
                cnt_d  = cnt_q;
                data_d = data_q;
                if (wr_sel) begin
                    cnt_d  = wr_clr_i ? '0 : wr_cnt_i;
                    data_d = wr_clr_i ? '0 : wr_data_i;
                end
            end

            // Entry storage, emptied on reset.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q  <= '0;
                    data_q <= '0;
                end else begin
                    cnt_q  <= cnt_d;
                    data_q <= data_d;
                end
            end
        end
    endgenerate

    // Read mux; out-of-range indices read as an empty prefix.
    always_comb begin
        rd_cnt_o  = '0;
        rd_data_o = '0;
        if (rd_idx_i <= LAST_IDX) begin
            rd_cnt_o  = cnt_all[rd_idx_i];
            rd_data_o = data_all[rd_idx_i];
        end
    end

endmodule

// File: rtl/lowent_prefix_ctrl.sv
// Low-entropy prefix sequencer: grows one prefix per codebook, asks the external
// codebook_select for a match, emits codewords, and drains prefixes on flush.
module lowent_prefix_ctrl
    import lowent_prefix_ctrl_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           sym_valid_i,
    output logic                           sym_ready_o,
    input  logic [CODE_W-1:0]              sym_code_i,
    input  logic [SYM_W-1:0]               sym_data_i,
    input  logic                           flush_i,
    output logic [CODE_W-1:0]              cb_select_o,
    output logic [CNT_W-1:0]               ap_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
    input  logic                           cb_match_i,
    input  logic [CNT_W-1:0]               cb_length_i,
    input  logic [ENCODE_DATALENGTH-1:0]   cb_data_i,
    output logic                           cw_valid_o,
    input  logic                           cw_ready_i,
    output logic                           cw_flush_o,
    output logic [LEN_W-1:0]               cw_length_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] cw_data_o,
    output logic                           flush_done_o,
    output logic                           overflow_o
);

    state_t                         state_q, state_d;
    logic [CODE_W-1:0]              code_q, code_d;
    logic [CNT_W-1:0]               cand_cnt_q, cand_cnt_d;
    logic [CODEBOOK_LENGTH_MAX-1:0] cand_data_q, cand_data_d;
    logic [LEN_W-1:0]               cw_len_q, cw_len_d;
    logic [CODEBOOK_LENGTH_MAX-1:0] cw_data_q, cw_data_d;
    logic                           cw_flush_q, cw_flush_d;
    logic [CODE_W-1:0]              scan_idx_q, scan_idx_d;
    logic                           overflow_q, overflow_d;
    logic                           flush_done_q, flush_done_d;

    logic [CODE_W-1:0]              rd_idx;
    logic [CNT_W-1:0]               rd_cnt;
    logic [CODEBOOK_LENGTH_MAX-1:0] rd_data;
    logic                           wr_en, wr_clr;
    logic [CODE_W-1:0]              wr_idx;
    logic                           code_ok;

    assign code_ok = (sym_code_i <= LAST_IDX);

    lowent_prefix_ctrl_ap_bank u_bank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx_i  (rd_idx),
        .rd_cnt_o  (rd_cnt),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_clr_i  (wr_clr),
        .wr_idx_i  (wr_idx),
        .wr_cnt_i  (cand_cnt_q),
        .wr_data_i (cand_data_q)
    );

    // Next-state, bank access and output decode.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        cand_cnt_d   = cand_cnt_q;
        cand_data_d  = cand_data_q;
        cw_len_d     = cw_len_q;
        cw_data_d    = cw_data_q;
        cw_flush_d   = cw_flush_q;
        scan_idx_d   = scan_idx_q;
        overflow_d   = overflow_q;
        flush_done_d = 1'b0;
        rd_idx       = '0;
        wr_en        = 1'b0;
        wr_clr       = 1'b0;
        wr_idx       = code_q;
        sym_ready_o  = 1'b0;
        cb_select_o  = '0;
        ap_cnt_o     = '0;
        ap_data_o    = '0;
        cw_valid_o   = 1'b0;
        cw_flush_o   = 1'b0;
        cw_length_o  = '0;
        cw_data_o    = '0;

        case (state_q)
            ST_IDLE: begin
                sym_ready_o = 1'b1;
                rd_idx      = code_ok ? sym_code_i : '0;
                if (sym_valid_i) begin
                    if (code_ok) begin
                        code_d      = sym_code_i;
                        cand_cnt_d  = rd_cnt + CNT_W'(1);
                        cand_data_d = (rd_data << SYM_W)
                                    | {{(CODEBOOK_LENGTH_MAX-SYM_W){1'b0}}, sym_data_i};
                        state_d     = ST_LOOKUP;
                    end else begin
                        // Unknown codebook: swallow the symbol, flag it.
                        overflow_d = 1'b1;
                    end
                end else if (flush_i) begin
                    scan_idx_d = '0;
                    state_d    = ST_FSCAN;
                end
            end

            ST_LOOKUP: begin
                cb_select_o = code_q;
                ap_cnt_o    = cand_cnt_q;
                ap_data_o   = cand_data_q;
                wr_en       = 1'b1;
                if (cb_match_i) begin
                    cw_len_d   = {1'b0, cb_length_i};
                    cw_data_d  = {{(CODEBOOK_LENGTH_MAX-ENCODE_DATALENGTH){1'b0}}, cb_data_i};
                    cw_flush_d = 1'b0;
                    wr_clr     = 1'b1;
                    state_d    = ST_EMIT;
                end else if (cand_cnt_q == CNT_MAX) begin
                    // Full prefix with no codeword: discard it.
                    overflow_d = 1'b1;
                    wr_clr     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EMIT: begin
                cw_valid_o  = 1'b1;
                cw_flush_o  = cw_flush_q;
                cw_length_o = cw_len_q;
                cw_data_o   = cw_data_q;
                if (cw_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_FSCAN: begin
                rd_idx = scan_idx_q;
                if (rd_cnt != '0) begin
                    cw_len_d   = cnt_to_bits(rd_cnt);
                    cw_data_d  = rd_data;
                    cw_flush_d = 1'b1;
                    state_d    = ST_FEMIT;
                end else if (scan_idx_q == LAST_IDX) begin
                    flush_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + CODE_W'(1);
                end
            end

            ST_FEMIT: begin
                cw_valid_o  = 1'b1;
                cw_flush_o  = cw_flush_q;
                cw_length_o = cw_len_q;
                cw_data_o   = cw_data_q;
                if (cw_ready_i) begin
                    wr_en  = 1'b1;
                    wr_clr = 1'b1;
                    wr_idx = scan_idx_q;
                    if (scan_idx_q == LAST_IDX) begin
                        flush_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        scan_idx_d = scan_idx_q + CODE_W'(1);
                        state_d    = ST_FSCAN;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            cand_cnt_q   <= '0;
            cand_data_q  <= '0;
            cw_len_q     <= '0;
            cw_data_q    <= '0;
            cw_flush_q   <= 1'b0;
            scan_idx_q   <= '0;
            overflow_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            cand_cnt_q   <= cand_cnt_d;
            cand_data_q  <= cand_data_d;
            cw_len_q     <= cw_len_d;
            cw_data_q    <= cw_data_d;
            cw_flush_q   <= cw_flush_d;
            scan_idx_q   <= scan_idx_d;
            overflow_q   <= overflow_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign overflow_o   = overflow_q;
    assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_lowent_prefix_ctrl.sv
// Bench for lowent_prefix_ctrl: directed scenarios plus randomized traffic,
// checked against a symbol-queue model of the prefixes and a codebook model.
module tb_lowent_prefix_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sym_valid_i = 1'b0;
    logic        sym_ready_o;
    logic [3:0]  sym_code_i = '0;
    logic [3:0]  sym_data_i = '0;
    logic        flush_i = 1'b0;
    logic [3:0]  cb_select_o;
    logic [5:0]  ap_cnt_o;
    logic [63:0] ap_data_o;
    logic        cb_match_i;
    logic [5:0]  cb_length_i;
    logic [20:0] cb_data_i;
    logic        cw_valid_o;
    logic        cw_ready_i = 1'b0;
    logic        cw_flush_o;
    logic [6:0]  cw_length_o;
    logic [63:0] cw_data_o;
    logic        flush_done_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;
    int match_mode = 0;
    int last_ap_cnt = 0;

    int unsigned msyms [12][$];
    bit          m_ovf = 1'b0;

    lowent_prefix_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sym_valid_i  (sym_valid_i),
        .sym_ready_o  (sym_ready_o),
        .sym_code_i   (sym_code_i),
        .sym_data_i   (sym_data_i),
        .flush_i      (flush_i),
        .cb_select_o  (cb_select_o),
        .ap_cnt_o     (ap_cnt_o),
        .ap_data_o    (ap_data_o),
        .cb_match_i   (cb_match_i),
        .cb_length_i  (cb_length_i),
        .cb_data_i    (cb_data_i),
        .cw_valid_o   (cw_valid_o),
        .cw_ready_i   (cw_ready_i),
        .cw_flush_o   (cw_flush_o),
        .cw_length_o  (cw_length_o),
        .cw_data_o    (cw_data_o),
        .flush_done_o (flush_done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Codebook rule: mode 0 never, mode 1 only {cnt=2,data=0}, mode 2 newest sym low bits 11.
    function automatic bit cb_hit(input int mode, input int cnt, input logic [63:0] d);
        case (mode)
            1:       return (cnt == 2) && (d == 64'h0);
            2:       return (cnt >= 2) && (d[1:0] == 2'b11);
            default: return 1'b0;
        endcase
    endfunction

    // Codebook: codeword length is cnt+3, data is low prefix bits xor codebook index.
    always_comb begin
        cb_match_i  = cb_hit(match_mode, int'(ap_cnt_o), ap_data_o);
        cb_length_i = 6'(int'(ap_cnt_o) + 3);
        cb_data_i   = ap_data_o[20:0] ^ 21'(cb_select_o);
    end

    // Prefix value from an ordered list of symbols, oldest first.
    function automatic logic [63:0] pack(input int unsigned q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = (v << 4) | 64'(q[i] & 4'hF);
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 12; i++) msyms[i].delete();
        m_ovf = 1'b0;
    endtask

    // One symbol through accept, lookup and (if matched) codeword handshake.
    task automatic send_sym(input int code, input int sym, input int hold);
        int unsigned q[$];
        int          ccnt;
        logic [63:0] cand;
        bit          hit;
        logic [6:0]  elen;
        logic [63:0] edata;

        total++;
        if (sym_ready_o !== 1'b1) begin
            bad++; $display("FAIL accept_ready: got %0b expected 1", sym_ready_o);
        end
        sym_valid_i = 1'b1;
        sym_code_i  = 4'(code);
        sym_data_i  = 4'(sym);
        step();
        sym_valid_i = 1'b0;

        if (code >= 12) begin
            m_ovf = 1'b1;
            total++;
            if (sym_ready_o !== 1'b1 || cw_valid_o !== 1'b0) begin
                bad++; $display("FAIL bad_code_idle: got ready=%0b valid=%0b expected 1/0", sym_ready_o, cw_valid_o);
            end
            total++;
            if (overflow_o !== 1'b1) begin
                bad++; $display("FAIL bad_code_ovf: got %0b expected 1", overflow_o);
            end
            $display("sym code=%0d data=%0h dropped", code, sym);
            return;
        end

        q = msyms[code];
        q.push_back(sym);
        ccnt = q.size();
        cand = pack(q);
        total++;
        if (cb_select_o !== 4'(code) || ap_cnt_o !== 6'(ccnt) || ap_data_o !== cand || sym_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL lookup: got sel=%0d cnt=%0d data=%0h rdy=%0b expected sel=%0d cnt=%0d data=%0h rdy=0",
                     cb_select_o, ap_cnt_o, ap_data_o, sym_ready_o, code, ccnt, cand);
        end
        last_ap_cnt = int'(ap_cnt_o);
        hit   = cb_hit(match_mode, ccnt, cand);
        elen  = 7'(ccnt + 3);
        edata = 64'(cand[20:0] ^ 21'(code));
        step();

        if (hit) begin
            msyms[code].delete();
            for (int h = 0; h <= hold; h++) begin
                total++;
                if (cw_valid_o !== 1'b1 || cw_flush_o !== 1'b0 || cw_length_o !== elen ||
                    cw_data_o !== edata || sym_ready_o !== 1'b0) begin
                    bad++;
                    $display("FAIL emit: got v=%0b f=%0b len=%0d data=%0h rdy=%0b expected 1/0/%0d/%0h/0",
                             cw_valid_o, cw_flush_o, cw_length_o, cw_data_o, sym_ready_o, elen, edata);
                end
                if (h < hold) step();
            end
            cw_ready_i = 1'b1;
            step();
            cw_ready_i = 1'b0;
        end else if (ccnt == 16) begin
            msyms[code].delete();
            m_ovf = 1'b1;
        end else begin
            msyms[code] = q;
        end

        total++;
        if (cw_valid_o !== 1'b0 || sym_ready_o !== 1'b1) begin
            bad++; $display("FAIL back_idle: got valid=%0b ready=%0b expected 0/1", cw_valid_o, sym_ready_o);
        end
        total++;
        if (overflow_o !== m_ovf) begin
            bad++; $display("FAIL overflow: got %0b expected %0b", overflow_o, m_ovf);
        end
        $display("sym code=%0d data=%0h cnt=%0d match=%0b", code, sym, ccnt, hit);
    endtask

    // Flush: expect one raw record per non-empty prefix in index order, then done.
    task automatic do_flush();
        int          exp_idx[$];
        bit          seen;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 12; i++) if (msyms[i].size() != 0) exp_idx.push_back(i);

        foreach (exp_idx[k]) begin
            seen = 1'b0;
            for (int w = 0; w < 30 && !seen; w++) begin
                if (flush_done_o === 1'b1) begin
                    total++; bad++; $display("FAIL early_done: got 1 expected 0");
                end
                if (cw_valid_o === 1'b1) seen = 1'b1;
                else step();
            end
            total++;
            if (!seen) begin
                bad++; $display("FAIL flush_wait: got no record expected index %0d", exp_idx[k]);
            end else if (cw_flush_o !== 1'b1 || cw_length_o !== 7'(msyms[exp_idx[k]].size() * 4) ||
                         cw_data_o !== pack(msyms[exp_idx[k]]) || sym_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL flush_rec: got f=%0b len=%0d data=%0h rdy=%0b expected 1/%0d/%0h/0",
                         cw_flush_o, cw_length_o, cw_data_o, sym_ready_o,
                         msyms[exp_idx[k]].size() * 4, pack(msyms[exp_idx[k]]));
            end
            $display("flush rec idx=%0d len=%0d data=%0h", exp_idx[k], cw_length_o, cw_data_o);
            cw_ready_i = 1'b1;
            step();
            cw_ready_i = 1'b0;
        end

        seen = 1'b0;
        for (int w = 0; w < 30 && !seen; w++) begin
            if (cw_valid_o === 1'b1) begin
                total++; bad++; $display("FAIL extra_rec: got len=%0d expected none", cw_length_o);
                cw_ready_i = 1'b1; step(); cw_ready_i = 1'b0;
            end else if (flush_done_o === 1'b1) seen = 1'b1;
            else step();
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL flush_done: got 0 expected 1");
        end
        step();
        total++;
        if (flush_done_o !== 1'b0 || sym_ready_o !== 1'b1) begin
            bad++; $display("FAIL done_pulse: got done=%0b ready=%0b expected 0/1", flush_done_o, sym_ready_o);
        end
        for (int i = 0; i < 12; i++) msyms[i].delete();
    endtask

    task automatic test_reset();
        reset_dut();
        total++;
        if (sym_ready_o !== 1'b1 || cw_valid_o !== 1'b0 || overflow_o !== 1'b0 || flush_done_o !== 1'b0 ||
            ap_cnt_o !== 6'd0 || cw_length_o !== 7'd0 || cw_data_o !== 64'd0 || cb_select_o !== 4'd0) begin
            bad++;
            $display("FAIL reset: got rdy=%0b v=%0b ovf=%0b done=%0b cnt=%0d len=%0d expected 1/0/0/0/0/0",
                     sym_ready_o, cw_valid_o, overflow_o, flush_done_o, ap_cnt_o, cw_length_o);
        end
    endtask

    task automatic test_match();
        reset_dut();
        match_mode = 1;
        send_sym(3, 0, 0);
        send_sym(3, 0, 0);
        send_sym(3, 5, 0);
        total++;
        if (last_ap_cnt != 1) begin
            bad++; $display("FAIL prefix3_empty: got %0d expected 1", last_ap_cnt);
        end
    endtask

    task automatic test_interleave();
        int exp_cnt[4] = '{1, 1, 2, 2};
        int codes[4]   = '{1, 5, 1, 5};
        reset_dut();
        match_mode = 0;
        for (int i = 0; i < 4; i++) begin
            send_sym(codes[i], i + 6, 0);
            total++;
            if (last_ap_cnt != exp_cnt[i]) begin
                bad++; $display("FAIL interleave_cnt: got %0d expected %0d", last_ap_cnt, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        match_mode = 0;
        for (int i = 0; i < 16; i++) send_sym(0, i, 0);
        total++;
        if (overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf16: got %0b expected 1", overflow_o);
        end
        send_sym(0, 9, 0);
        total++;
        if (last_ap_cnt != 1) begin
            bad++; $display("FAIL ovf_cleared: got %0d expected 1", last_ap_cnt);
        end
        send_sym(13, 2, 0);
    endtask

    task automatic test_flush();
        reset_dut();
        match_mode = 0;
        send_sym(2, 1, 0);
        send_sym(7, 2, 0);
        send_sym(7, 3, 0);
        total++;
        if (pack(msyms[7]) !== 64'h23) begin
            bad++; $display("FAIL model_prefix7: got %0h expected 23", pack(msyms[7]));
        end
        do_flush();
        do_flush();
        send_sym(7, 4, 0);
        total++;
        if (last_ap_cnt != 1) begin
            bad++; $display("FAIL flushed_empty: got %0d expected 1", last_ap_cnt);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        match_mode = 1;
        send_sym(3, 0, 0);
        send_sym(3, 0, 5);
        send_sym(3, 0, 0);
        send_sym(3, 0, 0);
    endtask

    task automatic test_reset_femit();
        bit seen = 1'b0;
        reset_dut();
        match_mode = 0;
        send_sym(4, 9, 0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int w = 0; w < 30 && !seen; w++) begin
            if (cw_valid_o === 1'b1) seen = 1'b1;
            else step();
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL femit_wait: got no record expected one");
        end
        rst_i = 1'b1;
        step();
        total++;
        if (cw_valid_o !== 1'b0 || sym_ready_o !== 1'b1 || flush_done_o !== 1'b0) begin
            bad++; $display("FAIL rst_femit: got v=%0b rdy=%0b done=%0b expected 0/1/0", cw_valid_o, sym_ready_o, flush_done_o);
        end
        rst_i = 1'b0;
        for (int i = 0; i < 12; i++) msyms[i].delete();
        m_ovf = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 15; w++) begin
            if (flush_done_o === 1'b1 || cw_valid_o === 1'b1) seen = 1'b1;
            step();
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL post_rst_quiet: got activity expected none");
        end
        send_sym(4, 1, 0);
        total++;
        if (last_ap_cnt != 1) begin
            bad++; $display("FAIL rst_cleared: got %0d expected 1", last_ap_cnt);
        end
    endtask

    task automatic test_random();
        int code;
        reset_dut();
        match_mode = 2;
        for (int n = 0; n < 300; n++) begin
            code = ($urandom_range(0, 19) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
            send_sym(code, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 39) == 0) do_flush();
        end
        do_flush();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match();
        test_interleave();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_femit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
